// File: rtl/register_file.sv
// register_file: 2**ADDR_WIDTH x DATA_WIDTH general-purpose registers, two async reads, one sync write.
// Latency: reads are combinational (0 cycles); a write is visible right after its committing clk edge.
// Backpressure: none; there is no handshake, and every enabled write with a nonzero address is accepted.
//
// Ports:
//   clk, reset                  - single clock; asynchronous active-high clear of all registers
//   read1_address, data1_out    - read port 1 (address in, contents out)
//   read2_address, data2_out    - read port 2 (address in, contents out)
//   write_enable, write_address,
//   data_in                     - write port, sampled on the rising clk edge
//
// Optional build macro REGISTER_BYPASS_EN: when defined, a read port whose address matches an
// enabled nonzero write this cycle forwards data_in combinationally (write-before-read).
// Register 0 always reads zero, and writes to it are discarded.

module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read1_address,
  input  logic [ADDR_WIDTH-1:0] read2_address,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data1_out,
  output logic [DATA_WIDTH-1:0] data2_out
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // A write is only meaningful for a nonzero destination; entry 0 is pinned to zero.
  logic write_hit;
  assign write_hit = write_enable && (write_address != '0);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (write_hit) begin
      regs_d[write_address] = data_in;
    end
    regs_d[0] = '0;
  end

  // Asynchronous reset wins over any write presented in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

`ifdef REGISTER_BYPASS_EN
  // Forward only when the write will actually commit: not in reset and not to register 0.
  logic fwd1;
  logic fwd2;
  assign fwd1 = write_hit && !reset && (read1_address == write_address);
  assign fwd2 = write_hit && !reset && (read2_address == write_address);
`endif

  always_comb begin
    data1_out = '0;
    if (read1_address != '0) begin
      data1_out = regs_q[read1_address];
    end
`ifdef REGISTER_BYPASS_EN
    if (fwd1) begin
      data1_out = data_in;
    end
`endif
  end

  always_comb begin
    data2_out = '0;
    if (read2_address != '0) begin
      data2_out = regs_q[read2_address];
    end
`ifdef REGISTER_BYPASS_EN
    if (fwd2) begin
      data2_out = data_in;
    end
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: randomized and directed stimulus for register_file, with a queue-based scoreboard.
// The stimulus thread pushes expected read data from a plain array model; a monitor pops and compares
// on the falling clk edge whenever a check is requested.

module tb_register_file;

  logic        clk;
  logic        reset;
  logic [4:0]  read1_address;
  logic [4:0]  read2_address;
  logic        write_enable;
  logic [4:0]  write_address;
  logic [31:0] data_in;
  logic [31:0] data1_out;
  logic [31:0] data2_out;

  register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .read1_address(read1_address),
    .read2_address(read2_address),
    .write_enable (write_enable),
    .write_address(write_address),
    .data_in      (data_in),
    .data1_out    (data1_out),
    .data2_out    (data2_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 32 words, plain array.
  logic [31:0] mem [32];

  logic [31:0] exp1_q [$];
  logic [31:0] exp2_q [$];
  string       name_q [$];
  logic        req;

  int n_cmp;
  int n_bad;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0 || reset) return 32'h0;
`ifdef REGISTER_BYPASS_EN
    if (write_enable && write_address == a) return data_in;
`endif
    return mem[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    write_enable  = we;
    write_address = wa;
    data_in       = wd;
    read1_address = r1;
    read2_address = r2;
  endtask

  // Called shortly after a rising edge; the monitor samples at the following falling edge.
  task automatic expect_now(input string name);
    exp1_q.push_back(model_read(read1_address));
    exp2_q.push_back(model_read(read2_address));
    name_q.push_back(name);
    req = 1'b1;
    @(negedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset && write_enable && write_address != 5'd0) mem[write_address] = data_in;
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (req) begin
      if (exp1_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow: check requested with empty expectation queue");
      end else begin
        logic [31:0] e1;
        logic [31:0] e2;
        string       nm;
        e1 = exp1_q.pop_front();
        e2 = exp2_q.pop_front();
        nm = name_q.pop_front();
        n_cmp++;
        if (data1_out !== e1) begin
          n_bad++;
          $display("FAIL %s port1: got %08h expected %08h (addr %0d) at %0t", nm, data1_out, e1,
                   read1_address, $time);
        end
        n_cmp++;
        if (data2_out !== e2) begin
          n_bad++;
          $display("FAIL %s port2: got %08h expected %08h (addr %0d) at %0t", nm, data2_out, e2,
                   read2_address, $time);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    req   = 1'b0;
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    clear_model();
    repeat (2) @(posedge clk);
    #1;

    // Reset held: every address reads zero on both ports; writes attempted are ignored.
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), $urandom, 5'(i), 5'(31 - i));
      expect_now("reset_sweep");
      step();
    end

    reset = 1'b0;

    // Write and read back, then swap ports.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    step();
    drive(1'b1, 5'd31, 32'h12345678, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    expect_now("write_readback");
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd5);
    expect_now("swap_ports");
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    expect_now("same_reg_both_ports");
    step();

    // Register 0 is hardwired to zero.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    expect_now("reg0_zero");
    step();

    // Write disabled leaves contents alone.
    drive(1'b1, 5'd7, 32'h00000011, 5'd0, 5'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd7, 32'hAAAAAAAA, 5'd7, 5'd7);
      step();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    expect_now("write_disabled");
    step();

    // Same-cycle read of the register being written.
    drive(1'b1, 5'd9, 32'h1, 5'd0, 5'd0);
    step();
    drive(1'b1, 5'd9, 32'h2, 5'd9, 5'd9);
    expect_now("same_cycle_before_edge");
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    expect_now("same_cycle_after_edge");
    step();

    // Asynchronous reset pulse between edges, then a write on the first edge after it.
    drive(1'b1, 5'd3, 32'hCAFEF00D, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    expect_now("pre_async_reset");
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd5);
    #1 reset = 1'b1;
    clear_model();
    #1 reset = 1'b0;
    expect_now("async_reset_clears");
    drive(1'b1, 5'd3, 32'h0BADF00D, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
    expect_now("write_after_reset");
    step();

    // Reset held across a write edge: the write is lost.
    drive(1'b1, 5'd4, 32'h44444444, 5'd4, 5'd4);
    reset = 1'b1;
    clear_model();
    step();
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd3);
    expect_now("reset_beats_write");
    step();

    // Random traffic, biased so reads often hit the write address.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa;
      logic [4:0] r1;
      logic [4:0] r2;
      wa = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wa, $urandom, r1, r2);
      expect_now("random");
      step();
    end

    // Final sweep of all registers against the model.
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      expect_now("final_sweep");
      step();
    end

    @(negedge clk);
    n_cmp++;
    if (exp1_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp1_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
